// File: rtl/bus_timer.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp and a level irq.
// Single-cycle bus slave; every request gets a registered response one cycle later.
module bus_timer #(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned PrescaleWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    dev_req_i,
    input  logic [AddressWidth-1:0] dev_addr_i,
    input  logic                    dev_we_i,
    input  logic [DataWidth-1:0]    dev_wdata_i,
    output logic [DataWidth-1:0]    dev_rdata_o,
    output logic                    dev_rvalid_o,
    output logic                    timer_irq_o
);

    typedef enum logic [2:0] {
        OffCtrl     = 3'd0,
        OffPrescale = 3'd1,
        OffMtimeLo  = 3'd2,
        OffMtimeHi  = 3'd3,
        OffCmpLo    = 3'd4,
        OffCmpHi    = 3'd5,
        OffStatus   = 3'd6,
        OffRsvd     = 3'd7
    } offset_e;

    logic                     ctrl_en_q, ctrl_en_d;
    logic                     ctrl_ie_q, ctrl_ie_d;
    logic [PrescaleWidth-1:0] prescale_q, prescale_d;
    logic [PrescaleWidth-1:0] pcnt_q, pcnt_d;
    logic [63:0]              mtime_q, mtime_d;
    logic [63:0]              mtimecmp_q, mtimecmp_d;
    logic [31:0]              shadow_q, shadow_d;
    logic [DataWidth-1:0]     rdata_q, rdata_d;
    logic                     rvalid_q;
    logic                     irq_q, irq_d;

    offset_e              offset;
    logic                 wr_en;
    logic                 rd_en;
    logic                 tick;
    logic                 cmp_ge;
    logic [DataWidth-1:0] rdata_mux;
    logic                 unused_addr;

    assign offset      = offset_e'(dev_addr_i[4:2]);
    assign wr_en       = dev_req_i & dev_we_i;
    assign rd_en       = dev_req_i & ~dev_we_i;
    assign tick        = ctrl_en_q && (pcnt_q == prescale_q);
    assign cmp_ge      = (mtime_q >= mtimecmp_q);
    assign unused_addr = ^{dev_addr_i[AddressWidth-1:5], dev_addr_i[1:0]};

    // Read mux works on pre-edge register values.
    always_comb begin
        rdata_mux = '0;
        case (offset)
            OffCtrl:     rdata_mux[1:0] = {ctrl_ie_q, ctrl_en_q};
            OffPrescale: rdata_mux[PrescaleWidth-1:0] = prescale_q;
            OffMtimeLo:  rdata_mux = mtime_q[31:0];
            OffMtimeHi:  rdata_mux = shadow_q;
            OffCmpLo:    rdata_mux = mtimecmp_q[31:0];
            OffCmpHi:    rdata_mux = mtimecmp_q[63:32];
            OffStatus:   rdata_mux[0] = cmp_ge;
            default:     rdata_mux = '0;
        endcase
    end

    always_comb begin
        ctrl_en_d  = ctrl_en_q;
        ctrl_ie_d  = ctrl_ie_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        shadow_d   = shadow_q;
        rdata_d    = '0;
        irq_d      = ctrl_ie_q & cmp_ge;

        if (ctrl_en_q) begin
            pcnt_d  = tick ? '0 : pcnt_q + 1'b1;
            mtime_d = mtime_q + 64'(tick);
        end

        if (rd_en) begin
            rdata_d = rdata_mux;
            if (offset == OffMtimeLo) begin
                shadow_d = mtime_q[63:32];
            end
        end

        // A bus write to an mtime half overrides the tick; the other half keeps its old value.
        if (wr_en) begin
            case (offset)
                OffCtrl: begin
                    ctrl_en_d = dev_wdata_i[0];
                    ctrl_ie_d = dev_wdata_i[1];
                end
                OffPrescale: begin
                    prescale_d = dev_wdata_i[PrescaleWidth-1:0];
                    pcnt_d     = '0;
                end
                OffMtimeLo: mtime_d    = {mtime_q[63:32], dev_wdata_i};
                OffMtimeHi: mtime_d    = {dev_wdata_i, mtime_q[31:0]};
                OffCmpLo:   mtimecmp_d = {mtimecmp_q[63:32], dev_wdata_i};
                OffCmpHi:   mtimecmp_d = {dev_wdata_i, mtimecmp_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ctrl_en_q  <= 1'b0;
            ctrl_ie_q  <= 1'b0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            shadow_q   <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_en_q  <= ctrl_en_d;
            ctrl_ie_q  <= ctrl_ie_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            shadow_q   <= shadow_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= dev_req_i;
            irq_q      <= irq_d;
        end
    end

    assign dev_rdata_o  = rdata_q;
    assign dev_rvalid_o = rvalid_q;
    assign timer_irq_o  = irq_q;

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: read expectations go into a scoreboard queue when the
// request is driven and are compared against responses captured on rvalid.
module tb_bus_timer;

    localparam logic [31:0] ACtrl     = 32'h00;
    localparam logic [31:0] APrescale = 32'h04;
    localparam logic [31:0] AMtimeLo  = 32'h08;
    localparam logic [31:0] AMtimeHi  = 32'h0C;
    localparam logic [31:0] ACmpLo    = 32'h10;
    localparam logic [31:0] ACmpHi    = 32'h14;
    localparam logic [31:0] AStatus   = 32'h18;
    localparam logic [31:0] ARsvd     = 32'h1C;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        irq;

    always #5 clk = ~clk;

    bus_timer #(
        .DataWidth    (32),
        .AddressWidth (32),
        .PrescaleWidth(16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .dev_req_i   (req),
        .dev_addr_i  (addr),
        .dev_we_i    (we),
        .dev_wdata_i (wdata),
        .dev_rdata_o (rdata),
        .dev_rvalid_o(rvalid),
        .timer_irq_o (irq)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
        int unsigned tol;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] got_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string name, input logic [31:0] val, input int unsigned tol);
        exp_t e;
        e.name = name;
        e.val  = val;
        e.tol  = tol;
        exp_q.push_back(e);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        req   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        cycle();
        req = 1'b0;
        we  = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a);
        req  = 1'b1;
        we   = 1'b0;
        addr = a;
        cycle();
        req = 1'b0;
        if (rvalid) got_q.push_back(rdata);
    endtask

    task automatic drain(input string tag);
        exp_t        e;
        logic [31:0] g;
        logic [31:0] diff;
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_resp_count: got %0d responses, want %0d",
                     tag, got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            g    = got_q.pop_front();
            diff = (g >= e.val) ? g - e.val : e.val - g;
            n_checks++;
            if ($isunknown(g) || diff > e.tol) begin
                n_fail++;
                $display("FAIL %s: got %h, want %h (tol %0d)", e.name, g, e.val, e.tol);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (2) cycle();
        rst = 1'b1;
        n_checks += 3;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_rdata: got %h, want 0", rdata);
        end
        if (rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rvalid: got %b, want 0", rvalid);
        end
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_irq: got %b, want 0", irq);
        end
        push_exp("rst_cmp_lo", 32'hFFFF_FFFF, 0);
        bus_rd(ACmpLo);
        cycle();
        n_checks++;
        if (rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rvalid_one_cycle: got %b, want 0", rvalid);
        end
        push_exp("rst_ctrl", 32'h0, 0);
        bus_rd(ACtrl);
        push_exp("rst_mtime_lo", 32'h0, 0);
        bus_rd(AMtimeLo);
        push_exp("rst_prescale", 32'h0, 0);
        bus_rd(APrescale);
        push_exp("rst_status", 32'h0, 0);
        bus_rd(AStatus);
        push_exp("rst_cmp_hi", 32'hFFFF_FFFF, 0);
        bus_rd(ACmpHi);
        drain("reset");
    endtask

    task automatic test_prescaler();
        bus_wr(APrescale, 32'd3);
        push_exp("ps_readback", 32'd3, 0);
        bus_rd(APrescale);
        bus_wr(ACtrl, 32'd1);
        repeat (40) cycle();
        push_exp("ps3_mtime", 32'd10, 1);
        bus_rd(AMtimeLo);
        bus_wr(ACtrl, 32'd0);
        bus_wr(AMtimeLo, 32'd0);
        bus_wr(AMtimeHi, 32'd0);
        bus_wr(APrescale, 32'd0);
        bus_wr(ACtrl, 32'd1);
        repeat (20) cycle();
        push_exp("ps0_mtime", 32'd20, 1);
        bus_rd(AMtimeLo);
        bus_wr(ACtrl, 32'd0);
        drain("prescaler");
    endtask

    task automatic test_carry();
        bus_wr(AMtimeHi, 32'd1);
        bus_wr(AMtimeLo, 32'hFFFF_FFFE);
        bus_wr(ACtrl, 32'd1);
        repeat (3) cycle();
        push_exp("carry_lo", 32'd1, 0);
        bus_rd(AMtimeLo);
        push_exp("carry_hi", 32'd2, 0);
        bus_rd(AMtimeHi);
        bus_wr(ACtrl, 32'd0);
        // Shadow must hold across a carry that happens between the two reads.
        bus_wr(AMtimeHi, 32'd5);
        bus_wr(AMtimeLo, 32'hFFFF_FFF0);
        bus_wr(ACtrl, 32'd1);
        push_exp("snap_lo", 32'hFFFF_FFF0, 0);
        bus_rd(AMtimeLo);
        repeat (30) cycle();
        push_exp("snap_hi_held", 32'd5, 0);
        bus_rd(AMtimeHi);
        push_exp("snap_lo_live", 32'h10, 1);
        bus_rd(AMtimeLo);
        push_exp("snap_hi_new", 32'd6, 0);
        bus_rd(AMtimeHi);
        bus_wr(ACtrl, 32'd0);
        drain("carry");
    endtask

    task automatic test_irq();
        logic want;
        bus_wr(AMtimeLo, 32'd0);
        bus_wr(AMtimeHi, 32'd0);
        bus_wr(ACmpHi, 32'd0);
        bus_wr(ACmpLo, 32'd50);
        bus_wr(APrescale, 32'd0);
        bus_wr(ACtrl, 32'd3);
        for (int k = 1; k <= 60; k++) begin
            cycle();
            want = (k >= 51);
            n_checks++;
            if (irq !== want) begin
                n_fail++;
                $display("FAIL irq_rise_k%0d: got %b, want %b", k, irq, want);
            end
        end
        push_exp("irq_status", 32'd1, 0);
        bus_rd(AStatus);
        bus_wr(ACmpLo, 32'd1000);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_hold_at_write: got %b, want 1", irq);
        end
        cycle();
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_fall: got %b, want 0", irq);
        end
        bus_wr(ACtrl, 32'd1);
        bus_wr(ACmpLo, 32'd10);
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_checks++;
            if (irq !== 1'b0) begin
                n_fail++;
                $display("FAIL irq_masked_%0d: got %b, want 0", k, irq);
            end
        end
        push_exp("irq_masked_status", 32'd1, 0);
        bus_rd(AStatus);
        drain("irq");
    endtask

    task automatic test_collision();
        push_exp("col_status", 32'd1, 0);
        bus_rd(AStatus);
        bus_wr(AMtimeHi, 32'd7);
        n_checks += 2;
        if (rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_rvalid: got %b, want 1", rvalid);
        end
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL wr_rdata: got %h, want 0", rdata);
        end
        bus_wr(AMtimeLo, 32'h100);
        repeat (5) cycle();
        push_exp("col_lo", 32'h105, 0);
        bus_rd(AMtimeLo);
        push_exp("col_hi", 32'd7, 0);
        bus_rd(AMtimeHi);
        push_exp("rsvd_read", 32'h0, 0);
        bus_rd(ARsvd);
        bus_wr(ARsvd, 32'hFFFF_FFFF);
        bus_wr(AStatus, 32'hFFFF_FFFF);
        push_exp("rsvd_ctrl", 32'd1, 0);
        bus_rd(ACtrl);
        push_exp("rsvd_prescale", 32'd0, 0);
        bus_rd(APrescale);
        push_exp("rsvd_cmp_lo", 32'd10, 0);
        bus_rd(ACmpLo);
        push_exp("rsvd_cmp_hi", 32'd0, 0);
        bus_rd(ACmpHi);
        drain("collision");
    endtask

    task automatic test_back_to_back();
        push_exp("b2b_ctrl", 32'd1, 0);
        push_exp("b2b_wr", 32'd0, 0);
        push_exp("b2b_prescale", 32'd9, 0);
        req  = 1'b1;
        we   = 1'b0;
        addr = ACtrl;
        cycle();
        if (rvalid) got_q.push_back(rdata);
        we    = 1'b1;
        addr  = APrescale;
        wdata = 32'd9;
        cycle();
        if (rvalid) got_q.push_back(rdata);
        we = 1'b0;
        cycle();
        if (rvalid) got_q.push_back(rdata);
        req = 1'b0;
        cycle();
        n_checks++;
        if (rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_rvalid_end: got %b, want 0", rvalid);
        end
        bus_wr(APrescale, 32'd0);
        drain("b2b");
    endtask

    task automatic test_reset_midrun();
        bus_wr(ACtrl, 32'd3);
        cycle();
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_irq_pre: got %b, want 1", irq);
        end
        req  = 1'b1;
        we   = 1'b0;
        addr = AMtimeLo;
        rst  = 1'b0;
        cycle();
        rst = 1'b1;
        req = 1'b0;
        n_checks += 3;
        if (rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rvalid: got %b, want 0", rvalid);
        end
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_irq: got %b, want 0", irq);
        end
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_rdata: got %h, want 0", rdata);
        end
        cycle();
        n_checks++;
        if (rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rvalid_late: got %b, want 0", rvalid);
        end
        push_exp("mid_mtime_lo", 32'd0, 0);
        bus_rd(AMtimeLo);
        push_exp("mid_mtime_hi", 32'd0, 0);
        bus_rd(AMtimeHi);
        push_exp("mid_ctrl", 32'd0, 0);
        bus_rd(ACtrl);
        push_exp("mid_cmp_lo", 32'hFFFF_FFFF, 0);
        bus_rd(ACmpLo);
        drain("midrun");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_prescaler();
        test_carry();
        test_irq();
        test_collision();
        test_back_to_back();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
